thd_sequencer: RTL and testbench

THD_SEQUENCER -- requirements
Module: thd_sequencer

---
 rtl/thd_sequencer_if.sv | 40 ++++
 rtl/thd_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_thd_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/thd_sequencer_if.sv
// thd_sequencer_if: bundles the frame request, harmonic stream, shared
// sqrt/divider handshakes and status/result signals of thd_sequencer.
//   slave  : the sequencer side (inputs start/fund/harm/done/result).
//   master : the environment side (drives requests, stream and sub-unit replies).
interface thd_sequencer_if;
  logic               start;
  logic signed [23:0] fund_re;
  logic signed [23:0] fund_im;
  logic               harm_valid;
  logic [47:0]        harm_sq;
  logic               harm_last;
  logic               sq_start;
  logic [47:0]        sq_operand;
  logic               sq_done;
  logic [23:0]        sq_result;
  logic               div_start;
  logic [23:0]        div_num;
  logic [23:0]        div_den;
  logic               div_done;
  logic [23:0]        div_quot;
  logic               busy;
  logic               thd_valid;
  logic [23:0]        thd_out;
  logic               err_zero;
  logic               err_timeout;

  modport slave (
    input  start, fund_re, fund_im, harm_valid, harm_sq, harm_last,
           sq_done, sq_result, div_done, div_quot,
    output sq_start, sq_operand, div_start, div_num, div_den,
           busy, thd_valid, thd_out, err_zero, err_timeout
  );

  modport master (
    output start, fund_re, fund_im, harm_valid, harm_sq, harm_last,
           sq_done, sq_result, div_done, div_quot,
    input  sq_start, sq_operand, div_start, div_num, div_den,
           busy, thd_valid, thd_out, err_zero, err_timeout
  );
endinterface

// File: rtl/thd_sequencer.sv
// thd_sequencer: per-frame THD sequencer. Accumulates harmonic power,
// takes sqrt of harmonic and fundamental power on a shared sqrt unit, then
// divides harmonic RMS by fundamental RMS on a shared divider.
// Ports:
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   bus (slave): start/fund_re/fund_im, harm_valid/harm_sq/harm_last,
//                sq_start/sq_operand/sq_done/sq_result,
//                div_start/div_num/div_den/div_done/div_quot,
//                busy/thd_valid/thd_out/err_zero/err_timeout
// Optional feature: define THD_TIMEOUT_EN to enable the wait-state watchdog
// (TIMEOUT cycles); otherwise err_timeout stays 0 and waits are unbounded.
module thd_sequencer #(
  parameter int unsigned MAX_HARM = 32,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic          clk,
  input  logic          rst,
  thd_sequencer_if.slave bus
);

  localparam int unsigned CW = $clog2(MAX_HARM + 1);

  typedef enum logic [3:0] {
    IDLE, ACCUM, SQ_H, WAIT_H, SQ_F, WAIT_F, DIV, WAIT_D, DONE
  } state_t;

  state_t             state_q, state_d;
  logic [47:0]        acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               acc_end_q, acc_end_d;
  logic signed [23:0] fre_q, fre_d, fim_q, fim_d;
  logic [23:0]        rms_h_q, rms_h_d;
  logic               sq_start_q, sq_start_d;
  logic [47:0]        sq_operand_q, sq_operand_d;
  logic               div_start_q, div_start_d;
  logic [23:0]        div_num_q, div_num_d, div_den_q, div_den_d;
  logic               busy_q, busy_d;
  logic               thd_valid_q, thd_valid_d;
  logic [23:0]        thd_out_q, thd_out_d;
  logic               err_zero_q, err_zero_d;
  logic               err_timeout_q, err_timeout_d;
  logic               wait_expired_c;

  // Saturating accumulate: carry out of the 48-bit add means clamp to all-ones
  logic [48:0] acc_sum_c;
  assign acc_sum_c = {1'b0, acc_q} + {1'b0, bus.harm_sq};

  // Fundamental power; each square is at most 2^46, so the sum fits 48 bits
  logic signed [47:0] re_sq_c, im_sq_c;
  logic [47:0]        fund_pwr_c;
  assign re_sq_c    = 48'(fre_q) * 48'(fre_q);
  assign im_sq_c    = 48'(fim_q) * 48'(fim_q);
  assign fund_pwr_c = $unsigned(re_sq_c) + $unsigned(im_sq_c);

`ifdef THD_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wait_cnt_q;
  logic          in_wait_c;
  assign in_wait_c = state_q inside {WAIT_H, WAIT_F, WAIT_D};

  // Cycles spent in the current wait state; restarts on every wait entry
  always_ff @(posedge clk) begin
    if (rst || !in_wait_c) wait_cnt_q <= '0;
    else                   wait_cnt_q <= wait_cnt_q + TW'(1);
  end
  assign wait_expired_c = in_wait_c && (wait_cnt_q == TW'(TIMEOUT - 1));
`else
  assign wait_expired_c = 1'b0;
`endif

  // Next-state and next-output logic; outputs are registered one edge later
  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    acc_end_d     = acc_end_q;
    fre_d         = fre_q;
    fim_d         = fim_q;
    rms_h_d       = rms_h_q;
    sq_operand_d  = sq_operand_q;
    div_num_d     = div_num_q;
    div_den_d     = div_den_q;
    thd_out_d     = thd_out_q;
    err_zero_d    = err_zero_q;
    err_timeout_d = err_timeout_q;
    sq_start_d    = 1'b0;
    div_start_d   = 1'b0;
    thd_valid_d   = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        fre_d         = bus.fund_re;
        fim_d         = bus.fund_im;
        acc_d         = '0;
        cnt_d         = '0;
        acc_end_d     = 1'b0;
        err_zero_d    = 1'b0;
        err_timeout_d = 1'b0;
        state_d       = ACCUM;
      end
      // Frame end is registered, so the exit happens the cycle after the
      // closing sample and stray samples in that cycle are dropped
      ACCUM: if (acc_end_q) begin
        sq_start_d   = 1'b1;
        sq_operand_d = acc_q;
        state_d      = SQ_H;
      end else if (bus.harm_valid) begin
        acc_d = acc_sum_c[48] ? '1 : acc_sum_c[47:0];
        cnt_d = cnt_q + CW'(1);
        if (bus.harm_last || (cnt_q == CW'(MAX_HARM - 1))) acc_end_d = 1'b1;
      end
      SQ_H: state_d = WAIT_H;
      WAIT_H: if (bus.sq_done) begin
        rms_h_d      = bus.sq_result;
        sq_start_d   = 1'b1;
        sq_operand_d = fund_pwr_c;
        state_d      = SQ_F;
      end else if (wait_expired_c) begin
        err_timeout_d = 1'b1;
        state_d       = IDLE;
      end
      SQ_F: state_d = WAIT_F;
      // Zero fundamental RMS bypasses the divider with a saturated result
      WAIT_F: if (bus.sq_done) begin
        if (bus.sq_result == 24'd0) begin
          thd_out_d   = '1;
          err_zero_d  = 1'b1;
          thd_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          div_start_d = 1'b1;
          div_num_d   = rms_h_q;
          div_den_d   = bus.sq_result;
          state_d     = DIV;
        end
      end else if (wait_expired_c) begin
        err_timeout_d = 1'b1;
        state_d       = IDLE;
      end
      DIV: state_d = WAIT_D;
      WAIT_D: if (bus.div_done) begin
        thd_out_d   = bus.div_quot;
        thd_valid_d = 1'b1;
        state_d     = DONE;
      end else if (wait_expired_c) begin
        err_timeout_d = 1'b1;
        state_d       = IDLE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      acc_q         <= '0;
      cnt_q         <= '0;
      acc_end_q     <= 1'b0;
      fre_q         <= '0;
      fim_q         <= '0;
      rms_h_q       <= '0;
      sq_start_q    <= 1'b0;
      sq_operand_q  <= '0;
      div_start_q   <= 1'b0;
      div_num_q     <= '0;
      div_den_q     <= '0;
      busy_q        <= 1'b0;
      thd_valid_q   <= 1'b0;
      thd_out_q     <= '0;
      err_zero_q    <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      acc_end_q     <= acc_end_d;
      fre_q         <= fre_d;
      fim_q         <= fim_d;
      rms_h_q       <= rms_h_d;
      sq_start_q    <= sq_start_d;
      sq_operand_q  <= sq_operand_d;
      div_start_q   <= div_start_d;
      div_num_q     <= div_num_d;
      div_den_q     <= div_den_d;
      busy_q        <= busy_d;
      thd_valid_q   <= thd_valid_d;
      thd_out_q     <= thd_out_d;
      err_zero_q    <= err_zero_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign bus.sq_start    = sq_start_q;
  assign bus.sq_operand  = sq_operand_q;
  assign bus.div_start   = div_start_q;
  assign bus.div_num     = div_num_q;
  assign bus.div_den     = div_den_q;
  assign bus.busy        = busy_q;
  assign bus.thd_valid   = thd_valid_q;
  assign bus.thd_out     = thd_out_q;
  assign bus.err_zero    = err_zero_q;
  // Never set when the watchdog is compiled out
  assign bus.err_timeout = err_timeout_q;

endmodule

// File: tb/tb_thd_sequencer.sv
// tb_thd_sequencer: directed bench for thd_sequencer with one-cycle sqrt and
// divider responders. Cycle k=0 is the cycle in which harm_last is driven.
module tb_thd_sequencer;
  localparam int unsigned MAX_HARM = 4;
  localparam int unsigned TIMEOUT  = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  thd_sequencer_if bus();

  thd_sequencer #(.MAX_HARM(MAX_HARM), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;
  int n_sq = 0, n_div = 0, n_tv = 0, n_both = 0;
  int ns, nd, nt, cyc, lat;
  logic        sq_hold = 1'b0, div_hold = 1'b0;
  logic        man_done = 1'b0;
  logic [23:0] man_res = '0;
  logic        sq_pend = 1'b0, div_pend = 1'b0;
  logic [23:0] sq_pres = '0, div_pres = '0;

  function automatic logic [23:0] isqrt(input logic [47:0] v);
    logic [63:0] r, t;
    r = '0;
    for (int i = 23; i >= 0; i--) begin
      t = r | (64'd1 << i);
      if (t * t <= {16'd0, v}) r = t;
    end
    return r[23:0];
  endfunction

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic v, input logic [47:0] d, input logic l);
    bus.harm_valid = v;
    bus.harm_sq    = d;
    bus.harm_last  = l;
    tick();
  endtask

  task automatic begin_frame(input logic signed [23:0] re, input logic signed [23:0] im);
    bus.start   = 1'b1;
    bus.fund_re = re;
    bus.fund_im = im;
    tick();
    bus.start   = 1'b0;
  endtask

  task automatic wait_valid(input int limit, output int n);
    n = 0;
    while (bus.thd_valid !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
  endtask

  // Two-sample frame; lat is cycles from the harm_last cycle to thd_valid
  task automatic frame(input logic signed [23:0] re, input logic signed [23:0] im,
                       input logic [47:0] s0, input logic [47:0] s1, output int l);
    int n;
    begin_frame(re, im);
    sample(1'b1, s0, 1'b0);
    sample(1'b1, s1, 1'b1);
    bus.harm_valid = 1'b0;
    bus.harm_last  = 1'b0;
    wait_valid(30, n);
    l = n + 1;
  endtask

  // Sub-unit responders (done one cycle after start) and output monitor
  initial begin
    bus.sq_done   = 1'b0;
    bus.sq_result = '0;
    bus.div_done  = 1'b0;
    bus.div_quot  = '0;
    forever begin
      @(negedge clk);
      if (bus.sq_start === 1'b1 && bus.div_start === 1'b1) n_both++;
      if (bus.sq_start === 1'b1) n_sq++;
      if (bus.div_start === 1'b1) n_div++;
      if (bus.thd_valid === 1'b1) n_tv++;
      bus.sq_done   = sq_pend | man_done;
      bus.sq_result = man_done ? man_res : sq_pres;
      sq_pend       = (bus.sq_start === 1'b1) && !sq_hold;
      sq_pres       = isqrt(bus.sq_operand);
      bus.div_done  = div_pend;
      bus.div_quot  = div_pres;
      div_pend      = (bus.div_start === 1'b1) && !div_hold;
      div_pres      = (bus.div_den != 24'd0) ? bus.div_num / bus.div_den : '1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.fund_re    = '0;
    bus.fund_im    = '0;
    bus.harm_valid = 1'b0;
    bus.harm_sq    = '0;
    bus.harm_last  = 1'b0;
    repeat (3) tick();
    check("rst_busy", bus.busy, 0);
    check("rst_thd_valid", bus.thd_valid, 0);
    check("rst_thd_out", bus.thd_out, 0);
    check("rst_err_zero", bus.err_zero, 0);
    check("rst_err_timeout", bus.err_timeout, 0);
    check("rst_sq_start", bus.sq_start, 0);
    check("rst_div_start", bus.div_start, 0);
    rst = 1'b0;
    tick();

    // Nominal frame: 3+4j, harmonics 9 and 16
    begin_frame(24'sd3, 24'sd4);
    check("nom_busy", bus.busy, 1);
    sample(1'b1, 48'd9, 1'b0);
    sample(1'b1, 48'd16, 1'b1);
    bus.harm_valid = 1'b0;
    bus.harm_last  = 1'b0;
    check("nom_k1_sq_start", bus.sq_start, 0);
    tick();
    check("nom_k2_sq_start", bus.sq_start, 1);
    check("nom_k2_operand", bus.sq_operand, 25);
    tick(); tick();
    check("nom_k4_sq_start", bus.sq_start, 1);
    check("nom_k4_operand", bus.sq_operand, 25);
    tick(); tick();
    check("nom_k6_div_start", bus.div_start, 1);
    check("nom_k6_sq_start", bus.sq_start, 0);
    check("nom_div_num", bus.div_num, 5);
    check("nom_div_den", bus.div_den, 5);
    tick(); tick();
    check("nom_k8_thd_valid", bus.thd_valid, 1);
    check("nom_thd_out", bus.thd_out, 1);
    check("nom_err_zero", bus.err_zero, 0);
    tick();
    check("nom_k9_thd_valid", bus.thd_valid, 0);
    check("nom_k9_busy", bus.busy, 0);
    tick(); tick();
    check("nom_thd_out_hold", bus.thd_out, 1);

    // Zero fundamental: divider bypassed
    nd = n_div;
    begin_frame(24'sd0, 24'sd0);
    sample(1'b1, 48'd100, 1'b1);
    bus.harm_valid = 1'b0;
    bus.harm_last  = 1'b0;
    tick();
    check("zero_k2_operand", bus.sq_operand, 100);
    tick(); tick();
    check("zero_k4_operand", bus.sq_operand, 0);
    tick(); tick();
    check("zero_k6_thd_valid", bus.thd_valid, 1);
    check("zero_thd_out", bus.thd_out, 24'hFFFFFF);
    check("zero_err_zero", bus.err_zero, 1);
    check("zero_no_div_start", n_div, nd);
    tick();
    check("zero_k7_busy", bus.busy, 0);
    tick(); tick();
    check("zero_err_zero_hold", bus.err_zero, 1);

    // Saturation and MAX_HARM cap with all-ones samples
    begin_frame(24'sd3, 24'sd4);
    check("cap_err_zero_cleared", bus.err_zero, 0);
    check("cap_thd_out_held", bus.thd_out, 24'hFFFFFF);
    for (int j = 0; j < 4; j++) sample(1'b1, 48'hFFFF_FFFF_FFFF, 1'b0);
    check("cap_j4_sq_start", bus.sq_start, 0);
    tick();
    bus.harm_valid = 1'b0;
    check("cap_j5_sq_start", bus.sq_start, 1);
    check("cap_sat_operand", bus.sq_operand, 48'hFFFF_FFFF_FFFF);
    wait_valid(20, cyc);
    check("cap_sqh_to_valid", cyc, 6);
    check("cap_thd_out", bus.thd_out, 24'h333333);
    tick();

    // Cap with small samples: fifth sample must not be added
    begin_frame(24'sd1, 24'sd0);
    for (int j = 0; j < 4; j++) sample(1'b1, 48'd1, 1'b0);
    check("cap1_j4_sq_start", bus.sq_start, 0);
    tick();
    bus.harm_valid = 1'b0;
    check("cap1_operand", bus.sq_operand, 4);
    wait_valid(20, cyc);
    check("cap1_thd_valid", bus.thd_valid, 1);
    check("cap1_thd_out", bus.thd_out, 2);
    tick();

    // Reset during WAIT_F, late sq_done afterwards
    begin_frame(24'sd3, 24'sd4);
    sample(1'b1, 48'd9, 1'b0);
    sample(1'b1, 48'd16, 1'b1);
    bus.harm_valid = 1'b0;
    bus.harm_last  = 1'b0;
    tick(); tick(); tick();
    check("rstw_k4_sq_start", bus.sq_start, 1);
    sq_hold = 1'b1;
    tick();
    check("rstw_k5_busy", bus.busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ns = n_sq; nd = n_div; nt = n_tv;
    check("rstw_busy", bus.busy, 0);
    check("rstw_thd_out", bus.thd_out, 0);
    check("rstw_operand", bus.sq_operand, 0);
    tick();
    man_done = 1'b1;
    man_res  = 24'd5;
    tick();
    man_done = 1'b0;
    tick(); tick();
    check("rstw_late_busy", bus.busy, 0);
    check("rstw_no_sq_start", n_sq, ns);
    check("rstw_no_div_start", n_div, nd);
    check("rstw_no_thd_valid", n_tv, nt);
    sq_hold = 1'b0;

    // Restart after reset
    frame(24'sd3, 24'sd4, 48'd9, 48'd16, lat);
    check("restart_latency", lat, 8);
    check("restart_thd_valid", bus.thd_valid, 1);
    check("restart_thd_out", bus.thd_out, 1);
    tick();

    // start pulses in ACCUM and WAIT_D are ignored
    begin_frame(24'sd6, 24'sd8);
    sample(1'b1, 48'd144, 1'b0);
    bus.harm_valid = 1'b0;
    bus.start      = 1'b1;
    bus.fund_re    = 24'sd100;
    bus.fund_im    = 24'sd0;
    tick();
    bus.start = 1'b0;
    sample(1'b1, 48'd256, 1'b1);
    bus.harm_valid = 1'b0;
    bus.harm_last  = 1'b0;
    tick();
    check("ign_k2_operand", bus.sq_operand, 400);
    tick(); tick();
    check("ign_k4_operand", bus.sq_operand, 100);
    tick(); tick();
    check("ign_div_num", bus.div_num, 20);
    check("ign_div_den", bus.div_den, 10);
    tick();
    bus.start   = 1'b1;
    bus.fund_re = 24'sd50;
    tick();
    bus.start = 1'b0;
    check("ign_k8_thd_valid", bus.thd_valid, 1);
    check("ign_thd_out", bus.thd_out, 2);
    tick();
    check("ign_k9_busy", bus.busy, 0);

`ifdef THD_TIMEOUT_EN
    // Withheld div_done trips the watchdog
    nt = n_tv;
    div_hold = 1'b1;
    begin_frame(24'sd3, 24'sd4);
    sample(1'b1, 48'd9, 1'b0);
    sample(1'b1, 48'd16, 1'b1);
    bus.harm_valid = 1'b0;
    bus.harm_last  = 1'b0;
    repeat (5) tick();
    check("to_k6_div_start", bus.div_start, 1);
    repeat (10) tick();
    check("to_k16_err_timeout", bus.err_timeout, 0);
    check("to_k16_busy", bus.busy, 1);
    tick();
    check("to_k17_err_timeout", bus.err_timeout, 1);
    check("to_k17_busy", bus.busy, 0);
    check("to_no_thd_valid", n_tv, nt);
    div_hold = 1'b0;
    tick();
    begin_frame(24'sd3, 24'sd4);
    check("to_err_timeout_cleared", bus.err_timeout, 0);
    sample(1'b1, 48'd9, 1'b0);
    sample(1'b1, 48'd16, 1'b1);
    bus.harm_valid = 1'b0;
    bus.harm_last  = 1'b0;
    wait_valid(30, cyc);
    check("to_next_latency", cyc + 1, 8);
    check("to_next_thd_out", bus.thd_out, 1);
    tick();
`endif

    check("start_exclusive", n_both, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
